// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state, opcode and counter definitions for seq_muldiv
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Counter is sized for the widest legal operand so every WIDTH shares one encoding.
  localparam int WIDTH_MAX = 32;
  localparam int CNT_W     = $clog2(WIDTH_MAX + 1);

endpackage

// File: rtl/addsub_n.sv
// rtl/addsub_n.sv - parametrised ripple adder/subtractor, subtract as x + ~y + 1
module addsub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         co
);

  always_comb begin : ripple
    logic [N:0]   c;
    logic [N-1:0] yy;
    yy   = y ^ {N{sub}};
    c    = '0;
    c[0] = sub;
    s    = '0;
    for (int i = 0; i < N; i++) begin
      s[i]   = x[i] ^ yy[i] ^ c[i];
      c[i+1] = (x[i] & yy[i]) | (x[i] & c[i]) | (yy[i] & c[i]);
    end
    co = c[N];
  end

endmodule

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock
import muldiv_pkg::*;

module seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_r;

  // acc_hi doubles as the remainder, acc_lo as the quotient, opnd as multiplicand or divisor.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             add_sub;
  logic [WIDTH:0]   add_s;
  logic             add_co;
  logic             unused_co;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  addsub_n #(.N(WIDTH + 1)) u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .s   (add_s),
    .co  (add_co)
  );

  assign unused_co = add_co;

  always_comb begin
    rem_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    add_x   = (op_r == OP_DIV) ? rem_sh : acc_hi;
    add_y   = {1'b0, opnd};
    add_sub = op_r;
    sum     = acc_hi;
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    if (op_r == OP_DIV) begin
      // Trial MSB set means the subtraction went negative: restore.
      if (!add_s[WIDTH]) begin
        nxt_hi = add_s;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum    = acc_lo[0] ? add_s : acc_hi;
      nxt_hi = {1'b0, sum[WIDTH:1]};
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      cnt       <= '0;
      op_r      <= OP_MUL;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            if (op == OP_DIV && b == '0) begin
              result_lo <= '1;
              result_hi <= a;
              div_zero  <= 1'b1;
              state     <= DONE;
            end else begin
              acc_hi <= '0;
              acc_lo <= a;
              opnd   <= b;
              cnt    <= CNT_W'(WIDTH);
              state  <= RUN;
            end
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result_lo <= nxt_lo;
            result_hi <= nxt_hi[WIDTH-1:0];
            div_zero  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - directed vector bench for seq_muldiv at WIDTH 8 and 16
module tb_seq_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;

  logic        busy8, done8, dz8;
  logic [7:0]  lo8, hi8;
  logic        busy16, done16, dz16;
  logic [15:0] lo16, hi16;

  int tests = 0;
  int fails = 0;
  int sel_r = 0;

  logic        cur_busy, cur_done, cur_dz;
  logic [31:0] cur_lo, cur_hi;

  typedef struct {
    int          sel;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8), .div_zero(dz8)
  );

  seq_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result_lo(lo16), .result_hi(hi16), .div_zero(dz16)
  );

  assign cur_busy = (sel_r != 0) ? busy16 : busy8;
  assign cur_done = (sel_r != 0) ? done16 : done8;
  assign cur_dz   = (sel_r != 0) ? dz16 : dz8;
  assign cur_lo   = (sel_r != 0) ? {16'd0, lo16} : {24'd0, lo8};
  assign cur_hi   = (sel_r != 0) ? {16'd0, hi16} : {24'd0, hi8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input logic o, input logic [31:0] a, input logic [31:0] b);
    op  = o;
    a8  = a[7:0];
    b8  = b[7:0];
    a16 = a[15:0];
    b16 = b[15:0];
  endtask

  task automatic set_start(input logic v);
    if (sel_r != 0) start16 = v;
    else start8 = v;
  endtask

  task automatic add_vec(input int sel, input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input logic dz);
    vec_t v;
    v.sel = sel; v.op = o; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.dz = dz;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, busy_cnt, exp_lat;
    bit got;
    sel_r = v.sel;
    exp_lat = v.dz ? 1 : ((v.sel != 0) ? 17 : 9);
    @(negedge clk);
    drive_ops(v.op, v.a, v.b);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    drive_ops(~v.op, $urandom, $urandom);
    lat = 0; busy_cnt = 0; got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (cur_busy) busy_cnt++;
      if (cur_done) got = 1;
    end
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({tag, " result_lo"}, cur_lo, v.lo);
    chk({tag, " result_hi"}, cur_hi, v.hi);
    chk({tag, " div_zero"}, 32'(cur_dz), 32'(v.dz));
    @(posedge clk);
    #1;
    chk({tag, " done_one_pulse"}, 32'(cur_done), 32'd0);
    chk({tag, " idle_busy"}, 32'(cur_busy), 32'd0);
    chk({tag, " result_hold"}, cur_lo, v.lo);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 32'(cur_busy), 32'd0);
    chk({tag, " done"}, 32'(cur_done), 32'd0);
    chk({tag, " lo"}, cur_lo, 32'd0);
    chk({tag, " hi"}, cur_hi, 32'd0);
    chk({tag, " dz"}, 32'(cur_dz), 32'd0);
  endtask

  // A second start during RUN must not disturb the first operation.
  task automatic ignored_start(input int sel, input string tag);
    int dones;
    logic [31:0] lo_seen, hi_seen;
    sel_r = sel;
    @(negedge clk);
    drive_ops(1'b0, 32'd200, 32'd150);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive_ops(1'b1, 32'd9, 32'd3);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    dones = 0; lo_seen = '0; hi_seen = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (cur_done) begin
        dones++;
        lo_seen = cur_lo;
        hi_seen = cur_hi;
      end
    end
    chk({tag, " done_count"}, 32'(dones), 32'd1);
    chk({tag, " lo"}, lo_seen, 32'h30 | ((sel != 0) ? 32'h7500 : 32'h0));
    chk({tag, " hi"}, hi_seen, (sel != 0) ? 32'h0 : 32'h75);
  endtask

  task automatic reset_midrun(input int sel, input string tag);
    int dones;
    sel_r = sel;
    @(negedge clk);
    drive_ops(1'b0, 32'd99, 32'd77);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero(tag);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (cur_done) dones++;
    end
    chk({tag, " no_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    vec_t v;
    add_vec(0, 1'b0, 200, 150, 32'h30, 32'h75, 1'b0);
    add_vec(0, 1'b0, 255, 255, 32'h01, 32'hFE, 1'b0);
    add_vec(0, 1'b0, 0, 77, 32'h00, 32'h00, 1'b0);
    add_vec(0, 1'b0, 128, 2, 32'h00, 32'h01, 1'b0);
    add_vec(0, 1'b1, 200, 7, 32'd28, 32'd4, 1'b0);
    add_vec(0, 1'b1, 3, 200, 32'd0, 32'd3, 1'b0);
    add_vec(0, 1'b1, 5, 0, 32'hFF, 32'h05, 1'b1);
    add_vec(0, 1'b1, 9, 3, 32'd3, 32'd0, 1'b0);
    add_vec(0, 1'b1, 255, 1, 32'd255, 32'd0, 1'b0);
    add_vec(0, 1'b1, 254, 255, 32'd0, 32'd254, 1'b0);
    add_vec(1, 1'b0, 200, 150, 32'h7530, 32'h0, 1'b0);
    add_vec(1, 1'b0, 65535, 65535, 32'h0001, 32'hFFFE, 1'b0);
    add_vec(1, 1'b0, 0, 77, 32'h0, 32'h0, 1'b0);
    add_vec(1, 1'b1, 200, 7, 32'd28, 32'd4, 1'b0);
    add_vec(1, 1'b1, 3, 200, 32'd0, 32'd3, 1'b0);
    add_vec(1, 1'b1, 5, 0, 32'hFFFF, 32'h5, 1'b1);
    add_vec(1, 1'b1, 9, 3, 32'd3, 32'd0, 1'b0);
    add_vec(1, 1'b1, 50000, 123, 32'd406, 32'd62, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    sel_r = 0;
    check_zero("reset8");
    sel_r = 1;
    check_zero("reset16");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_vec(v, $sformatf("vec%0d", i));
    end

    ignored_start(0, "ign8");
    ignored_start(1, "ign16");

    reset_midrun(0, "rst8");
    v.sel = 0; v.op = 1'b0; v.a = 13; v.b = 11; v.lo = 32'h8F; v.hi = 32'h0; v.dz = 1'b0;
    run_vec(v, "after_rst8");
    reset_midrun(1, "rst16");
    v.sel = 1; v.op = 1'b0; v.a = 65535; v.b = 65535; v.lo = 32'h0001; v.hi = 32'hFFFE; v.dz = 1'b0;
    run_vec(v, "after_rst16");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
